// File: rtl/pll_md_config.sv
// pll_md_config: multi-profile dynamic-configuration sequencer for the Gowin PLL MD port.
//
// Holds the PLL in reset, writes each register of the selected profile over the MD port,
// reads it back and checks it, releases reset and waits for lock. Failures are retried up
// to RETRY_MAX times before parking in an error state. Optionally re-runs the profile
// when lock is lost.
//
// Ports (all in the mdclk domain except pll_lock and reset):
//   mdclk, reset       clock, asynchronous active-high reset
//   cfg_we/prof/idx/   profile table write port ({addr,data} per entry)
//   cfg_addr/cfg_data
//   start, prof_sel    request to configure profile prof_sel
//   pll_rst            PLL reset output
//   pll_lock           raw (asynchronous) PLL lock input
//   md_opc/ainc/wdi    MD command bus to the PLL, md_rdo read data back
//   busy, locked,      status: sequence running, profile locked, sticky failure
//   error, err_code
//   retry_cnt          retries used in the current run
//   cur_prof           profile last accepted
module pll_md_config #(
    parameter int unsigned NUM_PROFILES     = 4,
    parameter int unsigned REGS_PER_PROFILE = 8,
    parameter int unsigned RST_CYCLES       = 16,
    parameter int unsigned LOCK_TIMEOUT     = 65535,
    parameter int unsigned RETRY_MAX        = 3,
    parameter int unsigned AUTO_RELOCK      = 1,
    localparam int unsigned PW   = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
    localparam int unsigned IW   = (REGS_PER_PROFILE > 1) ? $clog2(REGS_PER_PROFILE) : 1,
    localparam int unsigned RW   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1
) (
    input  logic          mdclk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_prof,
    input  logic [IW-1:0] cfg_idx,
    input  logic [7:0]    cfg_addr,
    input  logic [7:0]    cfg_data,
    input  logic          start,
    input  logic [PW-1:0] prof_sel,
    output logic          pll_rst,
    input  logic          pll_lock,
    output logic [1:0]    md_opc,
    output logic          md_ainc,
    output logic [7:0]    md_wdi,
    input  logic [7:0]    md_rdo,
    output logic          busy,
    output logic          locked,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [RW-1:0] retry_cnt,
    output logic [PW-1:0] cur_prof
);

    localparam int unsigned CMAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [1:0] OpNop     = 2'b00;
    localparam logic [1:0] OpSetAddr = 2'b01;
    localparam logic [1:0] OpWrite   = 2'b10;
    localparam logic [1:0] OpRead    = 2'b11;

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrReadback = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;

    typedef enum logic [3:0] {
        StIdle,
        StRst,
        StAddr,
        StWr,
        StRd,
        StChk,
        StRel,
        StWait,
        StFail,
        StLocked,
        StError
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [PW-1:0] cur_prof_q, cur_prof_d;
    logic          lock_meta, lock_s;
    logic [15:0]   entry;
    logic          accept;

    // Profile table, {addr, data} per entry; intentionally not reset.
    logic [15:0] tbl_q [NUM_PROFILES][REGS_PER_PROFILE];

    always_ff @(posedge mdclk) begin
        if (cfg_we) begin
            tbl_q[cfg_prof][cfg_idx] <= {cfg_addr, cfg_data};
        end
    end

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge mdclk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            err_code_q <= ErrNone;
            cur_prof_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            err_code_q <= err_code_d;
            cur_prof_q <= cur_prof_d;
        end
    end

    // Read live so a table write to the running profile is seen at the next entry fetch.
    assign entry  = tbl_q[cur_prof_q][idx_q];
    assign accept = start && ((state_q == StIdle) || (state_q == StLocked) ||
                              (state_q == StError));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        err_code_d = err_code_q;
        cur_prof_d = cur_prof_q;
        pll_rst    = 1'b1;
        md_opc     = OpNop;
        md_wdi     = 8'h00;
        busy       = 1'b0;
        locked     = 1'b0;
        error      = 1'b0;

        unique case (state_q)
            StIdle: ;
            StRst: begin
                busy = 1'b1;
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    idx_d   = '0;
                    state_d = StAddr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAddr: begin
                busy    = 1'b1;
                md_opc  = OpSetAddr;
                md_wdi  = entry[15:8];
                state_d = StWr;
            end
            StWr: begin
                busy    = 1'b1;
                md_opc  = OpWrite;
                md_wdi  = entry[7:0];
                state_d = StRd;
            end
            StRd: begin
                busy    = 1'b1;
                md_opc  = OpRead;
                state_d = StChk;
            end
            StChk: begin
                busy = 1'b1;
                if (md_rdo == entry[7:0]) begin
                    if (idx_q == IW'(REGS_PER_PROFILE - 1)) begin
                        state_d = StRel;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StAddr;
                    end
                end else begin
                    err_code_d = ErrReadback;
                    state_d    = StFail;
                end
            end
            StRel: begin
                busy    = 1'b1;
                pll_rst = 1'b0;
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                busy    = 1'b1;
                pll_rst = 1'b0;
                if (lock_s) begin
                    state_d = StLocked;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    err_code_d = ErrTimeout;
                    state_d    = StFail;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFail: begin
                busy = 1'b1;
                if (retry_q < RW'(RETRY_MAX)) begin
                    retry_d = retry_q + 1'b1;
                    cnt_d   = '0;
                    state_d = StRst;
                end else begin
                    state_d = StError;
                end
            end
            StLocked: begin
                pll_rst = 1'b0;
                locked  = 1'b1;
                if (!lock_s) begin
                    if (AUTO_RELOCK != 0) begin
                        retry_d = '0;
                        cnt_d   = '0;
                        state_d = StRst;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StError: begin
                error = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // A new request overrides whatever the idle-type state decided.
        if (accept) begin
            err_code_d = ErrNone;
            retry_d    = '0;
            cur_prof_d = prof_sel;
            cnt_d      = '0;
            state_d    = StRst;
        end
    end

    assign md_ainc   = 1'b0;
    assign err_code  = err_code_q;
    assign retry_cnt = retry_q;
    assign cur_prof  = cur_prof_q;

endmodule

// File: tb/tb_pll_md_config.sv
module tb_pll_md_config;

    logic       mdclk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_prof;
    logic [2:0] cfg_idx;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       start;
    logic [1:0] prof_sel;
    logic       pll_rst;
    logic       pll_lock;
    logic [1:0] md_opc;
    logic       md_ainc;
    logic [7:0] md_wdi;
    logic [7:0] md_rdo;
    logic       busy;
    logic       locked;
    logic       error;
    logic [1:0] err_code;
    logic [1:0] retry_cnt;
    logic [1:0] cur_prof;

    int errors = 0;
    int checks = 0;

    pll_md_config #(
        .NUM_PROFILES    (4),
        .REGS_PER_PROFILE(8),
        .RST_CYCLES      (16),
        .LOCK_TIMEOUT    (100),
        .RETRY_MAX       (3),
        .AUTO_RELOCK     (1)
    ) dut (
        .mdclk    (mdclk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_prof (cfg_prof),
        .cfg_idx  (cfg_idx),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .prof_sel (prof_sel),
        .pll_rst  (pll_rst),
        .pll_lock (pll_lock),
        .md_opc   (md_opc),
        .md_ainc  (md_ainc),
        .md_wdi   (md_wdi),
        .md_rdo   (md_rdo),
        .busy     (busy),
        .locked   (locked),
        .error    (error),
        .err_code (err_code),
        .retry_cnt(retry_cnt),
        .cur_prof (cur_prof)
    );

    always #5 mdclk = ~mdclk;

    // PLL MD slave model: echoes writes, read data valid the cycle after READ.
    logic [7:0] mem [256];
    logic [7:0] md_addr_r = 8'h00;
    logic       corrupt_req = 1'b0;
    logic       corrupt_done = 1'b0;
    logic       lock_en = 1'b1;
    logic       lock_drop = 1'b0;
    int         rel_cnt = 0;

    always @(posedge mdclk) begin
        case (md_opc)
            2'b01: md_addr_r <= md_wdi;
            2'b10: mem[md_addr_r] <= md_wdi;
            2'b11: begin
                if (corrupt_req && !corrupt_done && md_addr_r == 8'h13) begin
                    md_rdo       <= mem[md_addr_r] ^ 8'hFF;
                    corrupt_done <= 1'b1;
                end else begin
                    md_rdo <= mem[md_addr_r];
                end
            end
            default: ;
        endcase
        if (!corrupt_req) corrupt_done <= 1'b0;
    end

    // Lock model: lock roughly 50 cycles after reset release.
    always @(posedge mdclk) begin
        if (pll_rst) begin
            rel_cnt  <= 0;
            pll_lock <= 1'b0;
        end else begin
            if (rel_cnt < 1000) rel_cnt <= rel_cnt + 1;
            pll_lock <= lock_en && !lock_drop && (rel_cnt >= 49);
        end
    end

    // Scoreboard of expected MD commands (NOPs are not tracked).
    typedef struct packed {
        logic [1:0] opc;
        logic [7:0] wdi;
        logic       chk_wdi;
    } exp_t;

    exp_t exp_q[$];

    always @(negedge mdclk) begin
        exp_t e;
        if (md_opc === 2'b01 || md_opc === 2'b10 || md_opc === 2'b11) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL md_cmd unexpected: got opc=%b wdi=%h, expected no command",
                         md_opc, md_wdi);
            end else begin
                e = exp_q.pop_front();
                if (md_opc !== e.opc || (e.chk_wdi && md_wdi !== e.wdi)) begin
                    errors++;
                    $display("FAIL md_cmd: got opc=%b wdi=%h, expected opc=%b wdi=%h",
                             md_opc, md_wdi, e.opc, e.wdi);
                end
            end
        end
    end

    // Expected command stream for profile 1 (addr 0x10+i, data 0xA0+i), first n entries.
    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({2'b01, 8'(8'h10 + i), 1'b1});
            exp_q.push_back({2'b10, 8'(8'hA0 + i), 1'b1});
            exp_q.push_back({2'b11, 8'h00, 1'b0});
        end
    endtask

    task automatic pulse_start(input logic [1:0] p);
        @(negedge mdclk);
        start    = 1'b1;
        prof_sel = p;
        @(negedge mdclk);
        start    = 1'b0;
    endtask

    // sel: 0 locked, 1 error, 2 WRITE on bus, 3 reset released while busy
    task automatic wait_cond(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge mdclk);
            if ((sel == 0 && locked === 1'b1) || (sel == 1 && error === 1'b1) ||
                (sel == 2 && md_opc === 2'b10) ||
                (sel == 3 && busy === 1'b1 && pll_rst === 1'b0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge mdclk);
        checks++;
        if ({pll_rst, md_opc, md_wdi, md_ainc, busy, locked, error, err_code, retry_cnt,
             cur_prof} !== {1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL reset_values: got rst=%b opc=%b wdi=%h ainc=%b busy=%b lk=%b err=%b code=%b rc=%0d prof=%0d, expected rst=1 rest 0",
                     pll_rst, md_opc, md_wdi, md_ainc, busy, locked, error, err_code,
                     retry_cnt, cur_prof);
        end
        reset = 1'b0;
        repeat (2) @(negedge mdclk);
        checks++;
        if (busy !== 1'b0 || pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b pll_rst=%b, expected busy=0 pll_rst=1",
                     busy, pll_rst);
        end
    endtask

    task automatic test_clean_run();
        bit ok;
        for (int i = 0; i < 8; i++) begin
            @(negedge mdclk);
            cfg_we   = 1'b1;
            cfg_prof = 2'd1;
            cfg_idx  = 3'(i);
            cfg_addr = 8'(8'h10 + i);
            cfg_data = 8'(8'hA0 + i);
        end
        @(negedge mdclk);
        cfg_we = 1'b0;
        push_run(8);
        pulse_start(2'd1);
        checks++;
        if (busy !== 1'b1 || pll_rst !== 1'b1 || cur_prof !== 2'd1) begin
            errors++;
            $display("FAIL start_accept: got busy=%b pll_rst=%b cur_prof=%0d, expected 1 1 1",
                     busy, pll_rst, cur_prof);
        end
        wait_cond(0, 400, ok);
        checks++;
        if (!ok || busy !== 1'b0 || err_code !== 2'b00 || pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL clean_lock: got locked=%b busy=%b err_code=%b pll_rst=%b, expected 1 0 00 0",
                     locked, busy, err_code, pll_rst);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL clean_drain: got %0d commands outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_readback_retry();
        bit ok;
        corrupt_req = 1'b1;
        push_run(4);
        push_run(8);
        pulse_start(2'd1);
        wait_cond(0, 600, ok);
        checks++;
        if (!ok || err_code !== 2'b01 || retry_cnt !== 2'd1) begin
            errors++;
            $display("FAIL retry_lock: got locked=%b err_code=%b retry_cnt=%0d, expected 1 01 1",
                     locked, err_code, retry_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL retry_drain: got %0d commands outstanding, expected 0", exp_q.size());
        end
        corrupt_req = 1'b0;
    endtask

    task automatic test_lock_timeout();
        bit ok;
        lock_en = 1'b0;
        for (int r = 0; r < 4; r++) push_run(8);
        pulse_start(2'd1);
        wait_cond(1, 1500, ok);
        checks++;
        if (!ok || err_code !== 2'b10 || retry_cnt !== 2'd3 || pll_rst !== 1'b1 ||
            busy !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error: got error=%b err_code=%b retry_cnt=%0d pll_rst=%b busy=%b locked=%b, expected 1 10 3 1 0 0",
                     error, err_code, retry_cnt, pll_rst, busy, locked);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_drain: got %0d commands outstanding, expected 0", exp_q.size());
        end
        repeat (5) @(negedge mdclk);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: got error=%b, expected 1", error);
        end
        lock_en = 1'b1;
    endtask

    task automatic test_relock();
        bit ok;
        int n;
        push_run(8);
        pulse_start(2'd1);
        wait_cond(0, 400, ok);
        checks++;
        if (!ok || error !== 1'b0 || err_code !== 2'b00) begin
            errors++;
            $display("FAIL restart_from_error: got locked=%b error=%b err_code=%b, expected 1 0 00",
                     locked, error, err_code);
        end
        push_run(8);
        lock_drop = 1'b1;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge mdclk);
            n = i;
            if (locked === 1'b0) break;
        end
        checks++;
        if (n < 2 || n > 5 || locked !== 1'b0 || pll_rst !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_loss: got locked=%b after %0d cycles pll_rst=%b busy=%b, expected 0 in 2..5 cycles 1 1",
                     locked, n, pll_rst, busy);
        end
        if (n < 5) repeat (5 - n) @(negedge mdclk);
        lock_drop = 1'b0;
        wait_cond(0, 400, ok);
        checks++;
        if (!ok || cur_prof !== 2'd1 || retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL relock: got locked=%b cur_prof=%0d retry_cnt=%0d, expected 1 1 0",
                     locked, cur_prof, retry_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL relock_drain: got %0d commands outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        push_run(8);
        pulse_start(2'd1);
        wait_cond(2, 100, ok);
        start    = 1'b1;
        prof_sel = 2'd2;
        @(negedge mdclk);
        start = 1'b0;
        checks++;
        if (!ok || cur_prof !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored: got seen_wr=%b cur_prof=%0d busy=%b, expected 1 1 1",
                     ok, cur_prof, busy);
        end
        wait_cond(0, 400, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL busy_start_run: got locked=%b outstanding=%0d, expected 1 0",
                     locked, exp_q.size());
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        push_run(8);
        pulse_start(2'd1);
        wait_cond(3, 200, ok);
        repeat (3) @(negedge mdclk);
        checks++;
        if (!ok || pll_rst !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reach_wait: got seen=%b pll_rst=%b locked=%b, expected 1 0 0",
                     ok, pll_rst, locked);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({pll_rst, md_opc, md_wdi, busy, locked, error, err_code, retry_cnt, cur_prof} !==
            {1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL async_reset: got rst=%b opc=%b wdi=%h busy=%b lk=%b err=%b code=%b rc=%0d prof=%0d, expected rst=1 rest 0",
                     pll_rst, md_opc, md_wdi, busy, locked, error, err_code, retry_cnt,
                     cur_prof);
        end
        repeat (2) @(negedge mdclk);
        reset = 1'b0;
        push_run(8);
        pulse_start(2'd1);
        wait_cond(0, 400, ok);
        checks++;
        if (!ok || err_code !== 2'b00 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL run_after_reset: got locked=%b err_code=%b outstanding=%0d, expected 1 00 0",
                     locked, err_code, exp_q.size());
        end
    endtask

    initial begin
        reset    = 1'b1;
        cfg_we   = 1'b0;
        cfg_prof = 2'd0;
        cfg_idx  = 3'd0;
        cfg_addr = 8'h00;
        cfg_data = 8'h00;
        start    = 1'b0;
        prof_sel = 2'd0;
        test_reset();
        test_clean_run();
        test_readback_retry();
        test_lock_timeout();
        test_relock();
        test_start_while_busy();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_md_config.md
Name: pll_md_config

Overview:
- Multi-profile dynamic-configuration sequencer for the Gowin PLL MD port. It generalises the fixed single-setting PLL init to NUM_PROFILES runtime-selectable register profiles.
- Sequence per run: hold PLL in reset, write each register, read it back and check it, release reset, wait for lock. Adds retry on failure, lock-loss supervision and auto-relock.
- Sits between the host/strobe controller and Gowin_PLL_MOD, in the mdclk domain.

Parameters:
- NUM_PROFILES, 4, number of stored profiles (≥1).
- REGS_PER_PROFILE, 8, register writes per profile (≥1).
- RST_CYCLES, 16, mdclk cycles pll_rst is held before the first MD op (≥1).
- LOCK_TIMEOUT, 65535, mdclk cycles to wait for synchronised lock after reset release.
- RETRY_MAX, 3, number of full re-runs after a failure before the block enters ERROR.
- AUTO_RELOCK, 1, 1 = lock loss in LOCKED triggers a re-run of the current profile.

Ports:
- mdclk, in, 1, sole clock.
- reset, in, 1, asynchronous active-high reset.
- cfg_we, in, 1, write one profile table entry.
- cfg_prof, in, clog2(NUM_PROFILES), profile index of the table write.
- cfg_idx, in, clog2(REGS_PER_PROFILE), entry index of the table write.
- cfg_addr, in, 8, MD register address for the entry.
- cfg_data, in, 8, MD register data for the entry.
- start, in, 1, one-cycle request to configure profile prof_sel.
- prof_sel, in, clog2(NUM_PROFILES), profile captured on an accepted start.
- pll_rst, out, 1, PLL reset.
- pll_lock, in, 1, raw PLL lock (asynchronous).
- md_opc, out, 2, MD opcode: 00 NOP, 01 SET_ADDR, 10 WRITE, 11 READ.
- md_ainc, out, 1, always 0 (addressing is explicit).
- md_wdi, out, 8, MD write data or address.
- md_rdo, in, 8, MD read data, valid the cycle after READ.
- busy, out, 1, a sequence is in progress.
- locked, out, 1, configured profile is locked.
- error, out, 1, sticky failure after retries are exhausted.
- err_code, out, 2, 01 readback mismatch, 10 lock timeout, 00 none.
- retry_cnt, out, clog2(RETRY_MAX+1), retries used in the current run.
- cur_prof, out, clog2(NUM_PROFILES), profile last accepted.

Behaviour:
- Reset values:
  - pll_rst=1; md_opc=00; md_wdi=0; md_ainc=0.
  - busy=0; locked=0; error=0; err_code=0; retry_cnt=0; cur_prof=0.
  - FSM=IDLE.
  - Table contents are not reset; they are undefined until written.
- Table write: cfg_we writes {addr,data} at [cfg_prof][cfg_idx] in one cycle, accepted in any state. Writing the profile currently being sequenced takes effect from the next entry read.
- pll_lock passes through a 2-FF synchroniser (lock_s) with 2-cycle latency; all lock decisions use lock_s.
- start handling:
  - Accepted in IDLE, LOCKED or ERROR.
  - Ignored while busy.
  - Acceptance clears error, err_code and retry_cnt, captures cur_prof=prof_sel, and moves to RST.
- FSM states:
  - RST: pll_rst=1, busy=1, locked=0. Counts RST_CYCLES, then goes to ADDR with idx=0.
  - ADDR (1 cycle): md_opc=01, md_wdi=table[cur_prof][idx].addr.
  - WR (1 cycle): md_opc=10, md_wdi=table.data.
  - RD (1 cycle): md_opc=11.
  - CHK (1 cycle): md_opc=00. Compares md_rdo with data.
    - Equal and idx<REGS_PER_PROFILE-1: idx+1, go to ADDR.
    - Equal and idx=last: go to REL.
    - Unequal: FAIL with code 01.
  - REL (1 cycle): pll_rst=0, timer cleared, go to WAIT.
  - WAIT: timer increments.
    - lock_s=1: go to LOCKED.
    - Timer reaches LOCK_TIMEOUT with no lock: FAIL with code 10.
  - FAIL (1 cycle): err_code is latched.
    - retry_cnt<RETRY_MAX: retry_cnt+1, go to RST.
    - Otherwise: go to ERROR.
  - LOCKED: busy=0, locked=1.
    - lock_s falling with AUTO_RELOCK=1: locked=0, retry_cnt cleared, go to RST (same profile).
    - lock_s falling with AUTO_RELOCK=0: locked=0, go to IDLE.
  - ERROR: error=1, pll_rst=1, busy=0. Held until start or reset.
- Timing:
  - Each register costs exactly 4 cycles.
  - A clean run from start to locked=1 takes 1 + RST_CYCLES + 4*REGS_PER_PROFILE + 1 + lock latency (≥2 sync cycles + 1) cycles.
- pll_rst is high in every state except REL, WAIT and LOCKED.
- Reset asserted mid-sequence returns everything to reset values immediately. pll_rst goes high asynchronously.
- Simultaneous start and cfg_we: both are honoured. The table entry read for idx 0 occurs in ADDR, so it sees the new value.

Test Plan:
- Fill profile 1 with addr 0x10+i, data 0xA0+i. Bench model echoes writes and asserts lock 50 cycles after rst release. start with prof_sel=1 -> 8×(01,10,11,00) opcode pattern with matching addr/data, then locked=1, busy=0, err_code=0.
- Model corrupts the read of entry 3 once -> FAIL with err_code=01, retry_cnt=1, full re-run from RST, then locked=1.
- Model never locks, LOCK_TIMEOUT=100, RETRY_MAX=3 -> four runs, then error=1, err_code=10, retry_cnt=3, pll_rst=1.
- In LOCKED with AUTO_RELOCK=1, drop pll_lock for 5 cycles -> locked falls 2–3 cycles later, pll_rst=1, same profile is re-sequenced, locked=1 again.
- Pulse start while in WR -> ignored: cur_prof unchanged and the sequence continues uninterrupted.
- Assert reset during WAIT -> pll_rst=1 same cycle, all outputs at reset values; a subsequent start runs cleanly.
